serial_byte_deserializer: RTL and testbench

Serial-to-parallel front end that feeds the team's 8-bit parallel-in/parallel-out holding register. It collects a framed serial bit stream, one bit per `sin_valid` strobe, into a byte and checks an optional even-parity bit. It then presents the byte on `byte_out` with a single-cycle `load` pulse, which drives the register's enable input directly. No backpressure is supported: the downstream register always accepts `load`.

---
 rtl/serial_byte_deserializer.sv | 118 +++++++++++
 tb/tb_serial_byte_deserializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_deserializer.sv
// Serial-to-parallel front end: assembles framed serial bits into a byte,
// checks optional even parity, and pulses load when byte_out is updated.
module serial_byte_deserializer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sin,
    input  logic       sin_valid,
    input  logic       sync,
    output logic [7:0] byte_out,
    output logic       load,
    output logic       parity_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [3:0]  r_count;
    logic [7:0]  r_byte_out;
    logic        r_load;
    logic        r_parity_err;

    state_t      w_next_state;
    logic [7:0]  w_next_shift;
    logic [3:0]  w_next_count;
    logic [7:0]  w_shifted;
    logic [7:0]  w_commit_data;
    logic        w_commit;
    logic        w_perr;

    assign w_shifted = MSB_FIRST ? {r_shift[6:0], sin} : {sin, r_shift[7:1]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state  = r_state;
        w_next_shift  = r_shift;
        w_next_count  = r_count;
        w_commit_data = r_shift;
        w_commit      = 1'b0;
        w_perr        = 1'b0;

        if (sin_valid) begin
            if (sync) begin
                // A sync bit always opens a new frame, overriding any completion.
                w_next_state = SHIFT;
                w_next_shift = w_shifted;
                w_next_count = 4'd1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                    end
                    SHIFT: begin
                        w_next_shift = w_shifted;
                        w_next_count = r_count + 4'd1;
                        if (r_count == 4'd7) begin
                            if (PARITY_EN) begin
                                w_next_state = PARITY;
                            end else begin
                                w_next_state  = IDLE;
                                w_next_count  = 4'd0;
                                w_commit      = 1'b1;
                                w_commit_data = w_shifted;
                            end
                        end
                    end
                    PARITY: begin
                        w_next_state = IDLE;
                        w_next_count = 4'd0;
                        if ((^r_shift) ^ sin) begin
                            w_perr = 1'b1;
                        end else begin
                            w_commit = 1'b1;
                        end
                    end
                    default: begin
                        w_next_state = IDLE;
                        w_next_count = 4'd0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_shift      <= 8'h00;
            r_count      <= 4'd0;
            r_byte_out   <= 8'h00;
            r_load       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_shift      <= w_next_shift;
            r_count      <= w_next_count;
            r_load       <= w_commit;
            r_parity_err <= w_perr;
            if (w_commit) begin
                r_byte_out <= w_commit_data;
            end
        end
    end

    assign byte_out   = r_byte_out;
    assign load       = r_load;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Bench for serial_byte_deserializer: two configurations share one serial stream,
// each checked every cycle against a frame-level reference model.
module tb_serial_byte_deserializer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sync = 1'b0;

    logic [7:0] a_byte, b_byte;
    logic       a_load, b_load, a_perr, b_perr, a_busy, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_byte_deserializer #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .byte_out(a_byte), .load(a_load), .parity_err(a_perr), .busy(a_busy)
    );

    serial_byte_deserializer #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .byte_out(b_byte), .load(b_load), .parity_err(b_perr), .busy(b_busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits are kept in arrival order; the byte is built from them by bit position.
    function automatic logic [7:0] assemble(input logic [8:0] f, input bit msb);
        logic [7:0] d = '0;
        for (int i = 0; i < 8; i++) begin
            if (msb) d[7-i] = f[i];
            else     d[i]   = f[i];
        end
        return d;
    endfunction

    logic [8:0] fa = '0, fb = '0;
    int         na = 0, nb = 0;
    logic [7:0] ea_byte = 8'h00, eb_byte = 8'h00;
    logic       ea_load = 1'b0, eb_load = 1'b0, ea_perr = 1'b0;

    always @(posedge clk or negedge rstn) begin
        logic [7:0] d;
        if (!rstn) begin
            na = 0; nb = 0;
            ea_byte = 8'h00; eb_byte = 8'h00;
            ea_load = 1'b0; eb_load = 1'b0; ea_perr = 1'b0;
        end else begin
            ea_load = 1'b0; eb_load = 1'b0; ea_perr = 1'b0;
            if (sin_valid) begin
                if (sync) begin
                    fa = '0; fa[0] = sin; na = 1;
                    fb = '0; fb[0] = sin; nb = 1;
                end else begin
                    if (na > 0) begin fa[na] = sin; na++; end
                    if (nb > 0) begin fb[nb] = sin; nb++; end
                end
                if (na == 9) begin
                    d = assemble(fa, 1'b1);
                    if (((^d) ^ fa[8]) == 1'b0) begin ea_byte = d; ea_load = 1'b1; end
                    else ea_perr = 1'b1;
                    na = 0;
                end
                if (nb == 8) begin
                    eb_byte = assemble(fb, 1'b0);
                    eb_load = 1'b1;
                    nb = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("a_byte_out", a_byte, ea_byte);
        check("a_load", {7'b0, a_load}, {7'b0, ea_load});
        check("a_parity_err", {7'b0, a_perr}, {7'b0, ea_perr});
        check("a_busy", {7'b0, a_busy}, {7'b0, (na > 0)});
        check("b_byte_out", b_byte, eb_byte);
        check("b_load", {7'b0, b_load}, {7'b0, eb_load});
        check("b_parity_err", {7'b0, b_perr}, 8'h00);
        check("b_busy", {7'b0, b_busy}, {7'b0, (nb > 0)});
        check("a_load_perr_excl", {7'b0, a_load & a_perr}, 8'h00);
    end

    task automatic send_bit(input logic b, input logic s);
        sin = b; sin_valid = 1'b1; sync = s;
        @(posedge clk); #1;
        sin_valid = 1'b0; sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends a data byte MSB-first with sync on the first bit, then an optional parity bit.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], i == 7);
            if (gap > 0) idle(gap);
        end
        if (with_par) send_bit(par, 1'b0);
    endtask

    initial begin
        #2;
        check("reset_byte_out", a_byte, 8'h00);
        check("reset_load", {7'b0, a_load}, 8'h00);
        check("reset_busy", {7'b0, a_busy}, 8'h00);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // Basic frame: 8'hA5 with good parity.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("basic_load", {7'b0, a_load}, 8'h01);
        check("basic_byte", a_byte, 8'hA5);
        check("basic_perr", {7'b0, a_perr}, 8'h00);
        check("basic_busy_low", {7'b0, a_busy}, 8'h00);
        idle(1);
        check("basic_load_one_cycle", {7'b0, a_load}, 8'h00);
        idle(2);

        // Parity error: byte_out keeps the previous value.
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        check("perr_pulse", {7'b0, a_perr}, 8'h01);
        check("perr_no_load", {7'b0, a_load}, 8'h00);
        check("perr_byte_held", a_byte, 8'hA5);
        idle(1);
        check("perr_one_cycle", {7'b0, a_perr}, 8'h00);
        idle(2);

        // Resync: abort after 3 bits, then frame 8'h3C.
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        check("resync_load", {7'b0, a_load}, 8'h01);
        check("resync_byte", a_byte, 8'h3C);
        check("resync_no_perr", {7'b0, a_perr}, 8'h00);
        idle(2);

        // Gaps, then back-to-back frame with sync at the next edge.
        send_frame(8'h5A, 1'b1, 1'b0, 2);
        check("gap_load", {7'b0, a_load}, 8'h01);
        check("gap_byte", a_byte, 8'h5A);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        check("b2b_load", {7'b0, a_load}, 8'h01);
        check("b2b_byte", a_byte, 8'hFF);
        idle(2);

        // LSB-first, no parity: bits 1,0,0,0,0,0,0,0.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        check("lsb_load", {7'b0, b_load}, 8'h01);
        check("lsb_byte", b_byte, 8'h01);
        check("lsb_busy_low", {7'b0, b_busy}, 8'h00);
        idle(2);

        // Reset mid-frame, then a full 8'hC3 frame.
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        rstn = 1'b0;
        #1;
        check("rst_a_byte", a_byte, 8'h00);
        check("rst_a_busy", {7'b0, a_busy}, 8'h00);
        check("rst_b_byte", b_byte, 8'h00);
        check("rst_b_busy", {7'b0, b_busy}, 8'h00);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(1);
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        check("post_rst_load", {7'b0, a_load}, 8'h01);
        check("post_rst_byte", a_byte, 8'hC3);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
